// File: rtl/puf_auth_pkg.sv
// Shared types and default sizes for the PUF authentication checker.
// Optional feature macro: PUF_AUTH_MAJORITY_EN (3-sample majority enrollment).
package puf_auth_pkg;

    localparam int CHAL_W_DEF = 6;
    localparam int RESP_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        COMPARE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    typedef logic [3:0] hd_t;

endpackage

// File: rtl/puf_popcount.sv
// Combinational population count of a response-wide vector.
// Result is an hd_t, so W must stay at or below 15.
module puf_popcount
    import puf_auth_pkg::*;
#(
    parameter int W = RESP_W_DEF
) (
    input  logic [W-1:0] bits,
    output hd_t          count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + hd_t'(bits[i]);
        end
    end

endmodule

// File: rtl/puf_auth_checker.sv
// PUF response enrollment table and Hamming-distance verifier.
// Define PUF_AUTH_MAJORITY_EN to enroll the 2-of-3 majority of three samples.
module puf_auth_checker
    import puf_auth_pkg::*;
#(
    parameter int CHAL_W = CHAL_W_DEF,
    parameter int RESP_W = RESP_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RESP_VALID,
    input  logic [CHAL_W-1:0] CHALLENGE,
    input  logic [RESP_W-1:0] RESPONSE,
    input  logic              MODE,
    input  logic [3:0]        THRESH,
    input  logic              CLEAR,
    output logic              BUSY,
    output logic              RESULT_VALID,
    output logic              PASS,
    output logic [3:0]        HD,
    output logic              UNENROLLED,
    output logic              ENR_DONE,
    output logic [CHAL_W:0]   ENR_CNT,
    output logic              OVERRUN
);

    localparam int DEPTH = 1 << CHAL_W;
    localparam logic [CHAL_W:0] CNT_MAX = {1'b1, {CHAL_W{1'b0}}};

    // Reset asserts at once but releases only on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n_int;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    state_t state_q;
    state_t state_d;

    logic              start;
    logic              enr_step;
    logic              wr_en;
    logic [RESP_W-1:0] wr_data;

    logic [CHAL_W-1:0] chal_q;
    logic [RESP_W-1:0] resp_q;
    logic              mode_q;
    logic [3:0]        thresh_q;

    logic [RESP_W-1:0] tbl [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [RESP_W-1:0] rd_data;
    logic              rd_valid;

    hd_t hd_raw;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        if (CLEAR) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (RESP_VALID) begin
                        start   = 1'b1;
                        state_d = LOOKUP;
                    end
                end
                LOOKUP:  state_d = COMPARE;
                COMPARE: state_d = REPORT;
                REPORT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign enr_step = (state_q == COMPARE) && !CLEAR && mode_q;
    assign BUSY     = (state_q != IDLE);

    puf_popcount #(
        .W(RESP_W)
    ) u_popcount (
        .bits  (rd_data ^ resp_q),
        .count (hd_raw)
    );

`ifdef PUF_AUTH_MAJORITY_EN
    logic [RESP_W-1:0] smp1_q;
    logic [RESP_W-1:0] smp2_q;
    logic [CHAL_W-1:0] smp_chal_q;
    logic [1:0]        smp_cnt_q;
    logic              restart;

    always_comb begin
        restart = (smp_cnt_q == 2'd0) || (smp_chal_q != chal_q);
        wr_en   = enr_step && !restart && (smp_cnt_q == 2'd2);
        wr_data = (smp1_q & smp2_q)
                | (smp1_q & resp_q)
                | (smp2_q & resp_q);
    end

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            smp1_q     <= '0;
            smp2_q     <= '0;
            smp_chal_q <= '0;
            smp_cnt_q  <= '0;
        end else if (CLEAR) begin
            smp_cnt_q <= '0;
        end else if (start && !MODE) begin
            smp_cnt_q <= '0;
        end else if (enr_step) begin
            if (restart) begin
                smp1_q     <= resp_q;
                smp_chal_q <= chal_q;
                smp_cnt_q  <= 2'd1;
            end else if (smp_cnt_q == 2'd1) begin
                smp2_q    <= resp_q;
                smp_cnt_q <= 2'd2;
            end else begin
                smp_cnt_q <= '0;
            end
        end
    end
`else
    always_comb begin
        wr_en   = enr_step;
        wr_data = resp_q;
    end
`endif

    // Table data is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (state_q == LOOKUP) begin
            rd_data <= tbl[chal_q];
        end
        if (wr_en) begin
            tbl[chal_q] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            chal_q   <= '0;
            resp_q   <= '0;
            mode_q   <= 1'b0;
            thresh_q <= '0;
        end else if (start) begin
            chal_q   <= CHALLENGE;
            resp_q   <= RESPONSE;
            mode_q   <= MODE;
            thresh_q <= THRESH;
        end
    end

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rd_valid     <= 1'b0;
            vld_q        <= '0;
            ENR_CNT      <= '0;
            RESULT_VALID <= 1'b0;
            ENR_DONE     <= 1'b0;
            PASS         <= 1'b0;
            HD           <= '0;
            UNENROLLED   <= 1'b0;
            OVERRUN      <= 1'b0;
        end else begin
            RESULT_VALID <= 1'b0;
            ENR_DONE     <= 1'b0;
            if (CLEAR) begin
                vld_q   <= '0;
                ENR_CNT <= '0;
            end else begin
                if (RESP_VALID && BUSY) begin
                    OVERRUN <= 1'b1;
                end
                if (state_q == LOOKUP) begin
                    rd_valid <= vld_q[chal_q];
                end
                if (state_q == COMPARE && !mode_q) begin
                    RESULT_VALID <= 1'b1;
                    UNENROLLED   <= !rd_valid;
                    HD           <= rd_valid ? hd_raw : '0;
                    PASS         <= rd_valid && (hd_raw <= thresh_q);
                end
                if (wr_en) begin
                    vld_q[chal_q] <= 1'b1;
                    ENR_DONE      <= 1'b1;
                    if (!rd_valid && ENR_CNT != CNT_MAX) begin
                        ENR_CNT <= ENR_CNT + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_puf_auth_checker.sv
// Scoreboard bench for puf_auth_checker: directed scenarios plus random traffic.
// A table-level reference model predicts each result and enrollment pulse.
module tb_puf_auth_checker;

    logic       CLK;
    logic       RST_N;
    logic       RESP_VALID;
    logic [5:0] CHALLENGE;
    logic [7:0] RESPONSE;
    logic       MODE;
    logic [3:0] THRESH;
    logic       CLEAR;
    logic       BUSY;
    logic       RESULT_VALID;
    logic       PASS;
    logic [3:0] HD;
    logic       UNENROLLED;
    logic       ENR_DONE;
    logic [6:0] ENR_CNT;
    logic       OVERRUN;

    puf_auth_checker dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .RESP_VALID   (RESP_VALID),
        .CHALLENGE    (CHALLENGE),
        .RESPONSE     (RESPONSE),
        .MODE         (MODE),
        .THRESH       (THRESH),
        .CLEAR        (CLEAR),
        .BUSY         (BUSY),
        .RESULT_VALID (RESULT_VALID),
        .PASS         (PASS),
        .HD           (HD),
        .UNENROLLED   (UNENROLLED),
        .ENR_DONE     (ENR_DONE),
        .ENR_CNT      (ENR_CNT),
        .OVERRUN      (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit enr;
        bit pass;
        int hd;
        bit unen;
        int cnt;
        int cyc;
    } exp_t;

    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] m_tbl [64];
    bit         m_vld [64];
    int         m_cnt;
    int         s_cnt;
    int         s_ch;
    logic [7:0] s1;
    logic [7:0] s2;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
        m_cnt = 0;
        s_cnt = 0;
    endfunction

    function automatic void model_write(input int ch, input logic [7:0] r, input int at);
        exp_t e;
        if (!m_vld[ch]) m_cnt++;
        m_vld[ch] = 1'b1;
        m_tbl[ch] = r;
        e.enr = 1; e.pass = 0; e.hd = 0; e.unen = 0;
        e.cnt = m_cnt; e.cyc = at + 3;
        q.push_back(e);
    endfunction

    function automatic void model_req(input bit m, input int ch, input logic [7:0] r,
                                      input int thr, input int at);
        exp_t e;
        int d;
        if (!m) begin
            s_cnt = 0;
            d = $countones(m_tbl[ch] ^ r);
            e.enr  = 0;
            e.unen = !m_vld[ch];
            e.hd   = m_vld[ch] ? d : 0;
            e.pass = m_vld[ch] && (d <= thr);
            e.cnt  = m_cnt;
            e.cyc  = at + 3;
            q.push_back(e);
        end else begin
`ifdef PUF_AUTH_MAJORITY_EN
            if (s_cnt == 0 || s_ch != ch) begin
                s1 = r; s_ch = ch; s_cnt = 1;
            end else if (s_cnt == 1) begin
                s2 = r; s_cnt = 2;
            end else begin
                s_cnt = 0;
                model_write(ch, (s1 & s2) | (s1 & r) | (s2 & r), at);
            end
`else
            model_write(ch, r, at);
`endif
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic issue(input bit m, input int ch, input logic [7:0] r, input int thr);
        RESP_VALID = 1'b1;
        MODE       = m;
        CHALLENGE  = 6'(ch);
        RESPONSE   = r;
        THRESH     = 4'(thr);
        model_req(m, ch, r, thr, cyc);
        @(negedge CLK);
        RESP_VALID = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic enroll_full(input int ch, input logic [7:0] r);
`ifdef PUF_AUTH_MAJORITY_EN
        repeat (3) issue(1'b1, ch, r, 0);
`else
        issue(1'b1, ch, r, 0);
`endif
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        @(negedge CLK);
        check("rst_outs",
              {BUSY, RESULT_VALID, PASS, HD, UNENROLLED, ENR_DONE, ENR_CNT, OVERRUN}, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        model_clear();
        repeat (4) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RST_N && (RESULT_VALID || ENR_DONE)) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {RESULT_VALID, ENR_DONE}, 0);
            end else begin
                e = q.pop_front();
                check("enr_done", ENR_DONE, e.enr);
                check("result_valid", RESULT_VALID, !e.enr);
                check("latency", cyc, e.cyc);
                check("enr_cnt", ENR_CNT, e.cnt);
                if (!e.enr) begin
                    check("pass", PASS, e.pass);
                    check("hd", HD, e.hd);
                    check("unenrolled", UNENROLLED, e.unen);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N      = 1'b0;
        RESP_VALID = 1'b0;
        CHALLENGE  = '0;
        RESPONSE   = '0;
        MODE       = 1'b0;
        THRESH     = '0;
        CLEAR      = 1'b0;
        for (int i = 0; i < 64; i++) m_tbl[i] = 8'h00;
        model_clear();
        @(negedge CLK);
        do_reset();

        // Unenrolled entry, then exact match and distance thresholds
        issue(1'b0, 63, 8'h3C, 15);
        enroll_full(5, 8'hA5);
        check("cnt_after_enroll", ENR_CNT, 1);
        issue(1'b0, 5, 8'hA5, 0);
        issue(1'b0, 5, 8'h5A, 7);
        issue(1'b0, 5, 8'h5A, 8);
        issue(1'b0, 5, 8'hA4, 0);
        issue(1'b0, 5, 8'hA4, 1);

        // Re-enroll keeps the count
        enroll_full(5, 8'h11);
        check("cnt_reenroll", ENR_CNT, 1);
        issue(1'b0, 5, 8'h11, 0);

        // CLEAR while in LOOKUP aborts silently
        RESP_VALID = 1'b1; MODE = 1'b1; CHALLENGE = 6'd9; RESPONSE = 8'h77;
        @(negedge CLK);
        RESP_VALID = 1'b0;
        check("busy_lookup", BUSY, 1);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        model_clear();
        check("busy_after_clear", BUSY, 0);
        check("cnt_after_clear", ENR_CNT, 0);
        repeat (4) @(negedge CLK);
        issue(1'b0, 5, 8'h11, 0);

        // Overrun: second request one cycle later is dropped
        RESP_VALID = 1'b1; MODE = 1'b0; CHALLENGE = 6'd7; RESPONSE = 8'h01; THRESH = 4'd3;
        model_req(1'b0, 7, 8'h01, 3, cyc);
        @(negedge CLK);
        check("ovr_before", OVERRUN, 0);
        RESPONSE = 8'hFE;
        @(negedge CLK);
        RESP_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        check("overrun_set", OVERRUN, 1);
        issue(1'b0, 7, 8'h01, 3);
        check("overrun_sticky", OVERRUN, 1);
        do_reset();

        // RESP_VALID together with CLEAR is ignored
        RESP_VALID = 1'b1; CLEAR = 1'b1; MODE = 1'b1; CHALLENGE = 6'd4;
        @(negedge CLK);
        RESP_VALID = 1'b0; CLEAR = 1'b0;
        check("clear_rv_busy", BUSY, 0);
        check("clear_rv_ovr", OVERRUN, 0);
        repeat (3) @(negedge CLK);
        issue(1'b0, 4, 8'h00, 15);

`ifdef PUF_AUTH_MAJORITY_EN
        issue(1'b1, 2, 8'hF0, 0);
        issue(1'b1, 2, 8'hF1, 0);
        check("maj_cnt_partial", ENR_CNT, 0);
        issue(1'b1, 2, 8'h01, 0);
        issue(1'b0, 2, 8'hF1, 0);
        issue(1'b1, 3, 8'h0F, 0);
        issue(1'b1, 4, 8'h0F, 0);
        issue(1'b0, 4, 8'h0F, 0);
`endif

        // Fill every entry to reach the count ceiling
        for (int ch = 0; ch < 64; ch++) enroll_full(ch, 8'(ch * 37));
        check("cnt_full", ENR_CNT, 64);
        enroll_full(0, 8'h5A);
        check("cnt_saturated", ENR_CNT, 64);
        issue(1'b0, 0, 8'h5B, 1);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                CLEAR = 1'b1;
                @(negedge CLK);
                CLEAR = 1'b0;
                model_clear();
            end else begin
                issue(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 7)),
                      8'($urandom), int'($urandom_range(0, 15)));
            end
        end

        repeat (6) @(negedge CLK);
        check("pending_pulses", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
